// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, multi-cycle EX holds with
// timeout, and taken-branch flush/redirect for the 5-stage core.
module pipe_ctrl #(
    parameter int STALL_W    = 6,
    parameter int MC_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs1_addr,
    input  logic               id_rs1_re,
    input  logic [4:0]         id_rs2_addr,
    input  logic               id_rs2_re,
    input  logic               ex_is_load,
    input  logic [4:0]         ex_reg_waddr,
    input  logic               ex_mc_req,
    input  logic               ex_mc_done,
    input  logic               ex_branch_taken,
    input  logic [31:0]        ex_branch_target,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               mc_busy,
    output logic               mc_timeout,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam int MC_CNT_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MC = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_LU = STALL_W'(6'b000111);
    localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_t;

    state_t              state, next_state;
    logic [MC_CNT_W-1:0] mc_cnt, next_cnt;
    logic                timeout_hit;
    logic                load_use;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_is_load && (ex_reg_waddr != 5'd0) &&
                      ((id_rs1_re && (id_rs1_addr == ex_reg_waddr)) ||
                       (id_rs2_re && (id_rs2_addr == ex_reg_waddr)));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_state  = state;
        next_cnt    = mc_cnt;
        timeout_hit = 1'b0;
        stall       = '0;
        flush       = 1'b0;
        new_pc      = '0;
        mc_busy     = 1'b0;

        if (rst) begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush  = 1'b1;
                        new_pc = ex_branch_target;
                    end else if (ex_mc_req) begin
                        stall      = STALL_MC;
                        next_state = MC_WAIT;
                        next_cnt   = '0;
                    end else if (load_use) begin
                        stall = STALL_LU;
                    end
                end
                MC_WAIT: begin
                    mc_busy = 1'b1;
                    // Done wins over a simultaneous timeout: the result is valid.
                    if (ex_mc_done) begin
                        next_state = RUN;
                    end else if (mc_cnt == MC_LAST) begin
                        timeout_hit = 1'b1;
                        next_state  = RUN;
                    end else begin
                        stall    = STALL_MC;
                        next_cnt = mc_cnt + MC_CNT_W'(1);
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= RUN;
            mc_cnt       <= '0;
            mc_timeout   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state      <= next_state;
            mc_cnt     <= next_cnt;
            mc_timeout <= timeout_hit;
            if ((stall != '0) && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares against the DUT.
module tb_pipe_ctrl;

    localparam int MC_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs1_addr = '0;
    logic        id_rs1_re = 1'b0;
    logic [4:0]  id_rs2_addr = '0;
    logic        id_rs2_re = 1'b0;
    logic        ex_is_load = 1'b0;
    logic [4:0]  ex_reg_waddr = '0;
    logic        ex_mc_req = 1'b0;
    logic        ex_mc_done = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = '0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_timeout;
    logic [31:0] stall_cycles;

    pipe_ctrl #(.STALL_W(6), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs1_re(id_rs1_re),
        .id_rs2_addr(id_rs2_addr), .id_rs2_re(id_rs2_re),
        .ex_is_load(ex_is_load), .ex_reg_waddr(ex_reg_waddr),
        .ex_mc_req(ex_mc_req), .ex_mc_done(ex_mc_done),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .stall(stall), .flush(flush), .new_pc(new_pc), .mc_busy(mc_busy),
        .mc_timeout(mc_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
        logic        to;
        logic [31:0] sc;
        bit          chk_reg;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_sc = '0;
    bit          sc_known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".stall"}, 32'(stall), 32'(e.stall));
            check({e.name, ".flush"}, 32'(flush), 32'(e.flush));
            check({e.name, ".new_pc"}, new_pc, e.pc);
            check({e.name, ".mc_busy"}, 32'(mc_busy), 32'(e.busy));
            if (e.chk_reg) begin
                check({e.name, ".mc_timeout"}, 32'(mc_timeout), 32'(e.to));
                check({e.name, ".stall_cycles"}, stall_cycles, e.sc);
            end
        end
    end

    task automatic set_in(input logic ld, input logic [4:0] wa,
                          input logic [4:0] r1, input logic e1,
                          input logic [4:0] r2, input logic e2,
                          input logic br, input logic [31:0] tgt,
                          input logic req, input logic done);
        ex_is_load = ld;  ex_reg_waddr = wa;
        id_rs1_addr = r1; id_rs1_re = e1;
        id_rs2_addr = r2; id_rs2_re = e2;
        ex_branch_taken = br; ex_branch_target = tgt;
        ex_mc_req = req;  ex_mc_done = done;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // Queue the expected outputs for the cycle whose inputs are now applied,
    // then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [5:0] s, input logic f,
                       input logic [31:0] pc, input logic b, input logic t);
        exp_t e;
        e.name = name; e.stall = s; e.flush = f; e.pc = pc; e.busy = b;
        e.to = t; e.sc = exp_sc; e.chk_reg = sc_known;
        sb.push_back(e);
        if (!rst) begin
            exp_sc   = '0;
            sc_known = 1'b1;
        end else if (s != 6'd0 && exp_sc != 32'hFFFF_FFFF) begin
            exp_sc = exp_sc + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset: outputs forced low even with a branch or mc request present.
        rst = 1'b0; idle();
        cyc("rst0", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b0);
        cyc("rst1_forced", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1; idle();
        cyc("run_idle", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);

        // Load-use on rs1, one bubble only.
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc("lu_rs1", 6'b000111, 1'b0, 32'd0, 1'b0, 1'b0);
        idle();
        cyc("lu_after", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc("lu_sc1", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        set_in(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc("lu_rs2", 6'b000111, 1'b0, 32'd0, 1'b0, 1'b0);

        // Non-hazards.
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc("lu_x0", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        set_in(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc("lu_rs2_not_read", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        set_in(1'b1, 5'd9, 5'd9, 1'b0, 5'd2, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc("lu_rs1_not_read", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        set_in(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cyc("alu_no_hazard", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);

        // Branch beats load-use and mc request.
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
        cyc("br_over_lu", 6'b000000, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
        cyc("br_over_mc", 6'b000000, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        idle();
        cyc("br_stay_run", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);

        // Multi-cycle op finishing on the 10th cycle in MC_WAIT.
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc("mc_req", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0);
        idle();
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0);
            else if (i == 5) set_in(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            else idle();
            cyc($sformatf("mc_wait%0d", i), 6'b001111, 1'b0, 32'd0, 1'b1, 1'b0);
        end
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc("mc_done", 6'b000000, 1'b0, 32'd0, 1'b1, 1'b0);
        idle();
        cyc("mc_back_run", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);

        // Timeout from a clean counter: stall_cycles ends at MC_TIMEOUT.
        rst = 1'b0; idle();
        cyc("rst_pre_to", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc("to_req", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < MC_TIMEOUT - 1; i++)
            cyc($sformatf("to_wait%0d", i), 6'b001111, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc("to_last", 6'b000000, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc("to_pulse", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc("to_pulse_end", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        tests++;
        if (exp_sc != 32'(MC_TIMEOUT)) begin
            fails++;
            $display("FAIL to_sc_plan: vector count %0d, expected %0d", exp_sc, MC_TIMEOUT);
        end

        // Done coincident with the timeout cycle counts as done.
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc("dt_req", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < MC_TIMEOUT - 1; i++)
            cyc($sformatf("dt_wait%0d", i), 6'b001111, 1'b0, 32'd0, 1'b1, 1'b0);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc("dt_last", 6'b000000, 1'b0, 32'd0, 1'b1, 1'b0);
        idle();
        cyc("dt_no_pulse", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);

        // Reset mid-wait, then a late done is ignored in RUN.
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc("rw_req", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 5; i++)
            cyc($sformatf("rw_wait%0d", i), 6'b001111, 1'b0, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
        cyc("rw_rst", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("rw_run", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cyc("rw_late_done", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);
        idle();
        cyc("rw_end", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
